mem_stage: RTL

Memory-access stage of the MIPS pipeline, between the EX/MEM register and the writeback mux. Drives the external data-memory bus with a req/ready handshake, stalls the pipeline while an access is outstanding, aligns and extends load data, and holds the MEM/WB pipeline register so writeback sees registered results.

---
 rtl/mem_stage_pkg.sv | 65 ++++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: access sizes, writeback sources, FSM states, bus/MEM-WB records.
// No logic of its own; lane helpers are pure combinational functions.
// No flow control; consumers own all handshaking.
package mem_stage_pkg;

    localparam int PC_BITS = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    typedef struct packed {
        logic [PC_BITS-1:0] addr;
        logic               we;
        logic [3:0]         be;
        logic [PC_BITS-1:0] wdata;
    } dmem_bus_t;

    typedef struct packed {
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic [PC_BITS-1:0] alu_out;
        logic [PC_BITS-1:0] read_data;
        logic [4:0]         write_reg;
        logic [PC_BITS-1:0] pc_plus_4;
        logic               addr_err;
    } mem_wb_t;

    // Half accesses only look at addr[1]; addr[0] matters for bytes alone.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << lo;
            MEM_HALF: be = 4'b0011 << {lo[1], 1'b0};
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [PC_BITS-1:0] lane_wdata(input logic [1:0] size,
                                                      input logic [PC_BITS-1:0] data);
        logic [PC_BITS-1:0] wd;
        case (size)
            MEM_BYTE: wd = {4{data[7:0]}};
            MEM_HALF: wd = {2{data[15:0]}};
            default:  wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension of the returned memory word.
// Latency: purely combinational.
// Backpressure: none; result is only meaningful while dmem_rdata is valid.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [PC_BITS-1:0] dmem_rdata,
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         mem_size,
    output logic [PC_BITS-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel  = dmem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        sext      = ~mem_size[2];
        load_data = dmem_rdata;
        case (mem_size[1:0])
            MEM_BYTE: load_data = {{(PC_BITS-8){sext & byte_sel[7]}}, byte_sel};
            MEM_HALF: load_data = {{(PC_BITS-16){sext & half_sel[15]}}, half_sel};
            default:  load_data = dmem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory req/ready master, load alignment and the MEM/WB register.
// Latency: non-memory ops 1 cycle; accesses IDLE->BUSY->DONE, 2 stall cycles plus one per wait cycle.
// Backpressure: stall_m freezes upstream while an access is outstanding; MEM_ALIGN_CHECK_EN enables misalignment trapping.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               reg_write_m,
    input  logic [1:0]         mem_to_reg_m,
    input  logic               mem_write_m,
    input  logic [2:0]         mem_size_m,
    input  logic [PC_BITS-1:0] alu_out_m,
    input  logic [PC_BITS-1:0] write_data_m,
    input  logic [4:0]         write_reg_m,
    input  logic [PC_BITS-1:0] pc_plus_4m,
    input  logic               dmem_ready,
    input  logic [PC_BITS-1:0] dmem_rdata,
    output logic               stall_m,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [PC_BITS-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [PC_BITS-1:0] dmem_wdata,
    output logic               reg_write_w,
    output logic [1:0]         mem_to_reg_w,
    output logic [PC_BITS-1:0] alu_out_w,
    output logic [PC_BITS-1:0] read_data_w,
    output logic [4:0]         write_reg_w,
    output logic [PC_BITS-1:0] pc_plus_4w,
    output logic               addr_err_w
);

    mem_state_t         state_q, state_d;
    dmem_bus_t          bus_q, bus_d;
    mem_wb_t            wb_q;
    logic [1:0]         addr_lo_q;
    logic [2:0]         size_q;
    logic [PC_BITS-1:0] load_q;
    logic [PC_BITS-1:0] load_data;
    logic               access, misalign, start;
    logic               latch_bus, capture;

    assign access = mem_write_m | (mem_to_reg_m == WB_MEM);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access &
                      (((mem_size_m[1:0] == MEM_HALF) & alu_out_m[0]) |
                       ((mem_size_m[1:0] == MEM_WORD) & (|alu_out_m[1:0])));
`else
    assign misalign = 1'b0;
`endif

    assign start = access & ~misalign;

    always_comb begin
        state_d   = state_q;
        stall_m   = 1'b0;
        dmem_req  = 1'b0;
        latch_bus = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                stall_m   = start;
                latch_bus = start;
                if (start) state_d = BUSY;
            end
            BUSY: begin
                stall_m  = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            // Instruction is still in MEM here, so MEM/WB latches it on this edge.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_d.addr  = {alu_out_m[PC_BITS-1:2], 2'b00};
        bus_d.we    = mem_write_m;
        bus_d.be    = lane_enables(mem_size_m[1:0], alu_out_m[1:0]);
        bus_d.wdata = lane_wdata(mem_size_m[1:0], write_data_m);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            bus_q     <= '0;
            addr_lo_q <= '0;
            size_q    <= '0;
            load_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_bus) begin
                bus_q     <= bus_d;
                addr_lo_q <= alu_out_m[1:0];
                size_q    <= mem_size_m;
            end
            if (capture && !bus_q.we) load_q <= load_data;
        end
    end

    mem_load_align u_load_align (
        .dmem_rdata (dmem_rdata),
        .addr_lo    (addr_lo_q),
        .mem_size   (size_q),
        .load_data  (load_data)
    );

    // Stalled cycles insert a bubble: control bits cleared, datapath fields held.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wb_q <= '0;
        end else if (stall_m) begin
            wb_q.reg_write  <= 1'b0;
            wb_q.mem_to_reg <= WB_ALU;
            wb_q.addr_err   <= 1'b0;
        end else begin
            wb_q.reg_write  <= reg_write_m & ~misalign;
            wb_q.mem_to_reg <= mem_to_reg_m;
            wb_q.alu_out    <= alu_out_m;
            wb_q.read_data  <= load_q;
            wb_q.write_reg  <= write_reg_m;
            wb_q.pc_plus_4  <= pc_plus_4m;
            wb_q.addr_err   <= misalign;
        end
    end

    assign dmem_addr    = bus_q.addr;
    assign dmem_we      = bus_q.we;
    assign dmem_be      = bus_q.be;
    assign dmem_wdata   = bus_q.wdata;

    assign reg_write_w  = wb_q.reg_write;
    assign mem_to_reg_w = wb_q.mem_to_reg;
    assign alu_out_w    = wb_q.alu_out;
    assign read_data_w  = wb_q.read_data;
    assign write_reg_w  = wb_q.write_reg;
    assign pc_plus_4w   = wb_q.pc_plus_4;
    assign addr_err_w   = wb_q.addr_err;

endmodule
